// File: rtl/mult_pkg.sv
// Shared sizing helpers for the pipelined Wallace multiplier: CSA tree depth,
// rows left after each 3:2 layer, product width and the stage-valid vector type.
package mult_pkg;

  localparam int MAX_STAGES = 3;

  typedef logic [MAX_STAGES-1:0] stage_valid_t;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  // Each full group of three rows becomes two; leftover rows pass through.
  function automatic int rows_after(input int n, input int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      if (r > 2) r = 2 * (r / 3) + r % 3;
    end
    return r;
  endfunction

  function automatic int csa_depth(input int n);
    int r;
    int d;
    r = n;
    d = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/csa_layer.sv
// One combinational 3:2 carry-save layer: rows are taken in threes, each group
// yields a sum row and a left-shifted carry row; leftover rows pass through.
module csa_layer
  import mult_pkg::*;
#(
  parameter int ROWS_IN = 3,
  parameter int W       = 16
) (
  input  logic [ROWS_IN-1:0][W-1:0]               rows_i,
  output logic [rows_after(ROWS_IN, 1)-1:0][W-1:0] rows_o
);

  localparam int GROUPS = ROWS_IN / 3;
  localparam int PASS   = ROWS_IN % 3;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_csa
    logic [W-1:0] x, y, z, maj;
    assign x   = rows_i[3*gi];
    assign y   = rows_i[3*gi+1];
    assign z   = rows_i[3*gi+2];
    assign maj = (x & y) | (x & z) | (y & z);
    assign rows_o[2*gi]   = x ^ y ^ z;
    // Carry out of the top bit falls off: arithmetic is modulo 2^W.
    assign rows_o[2*gi+1] = {maj[W-2:0], 1'b0};
  end

  for (genvar gi = 0; gi < PASS; gi++) begin : g_pass
    assign rows_o[2*GROUPS+gi] = rows_i[3*GROUPS+gi];
  end

endmodule

// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined NxN Wallace-tree multiplier with valid/ready flow control and tag
// sideband. Define MULT_SIGNED_EN to enable per-transaction Baugh-Wooley signed mode.
module pipelined_wallace_multiplier
  import mult_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int TREE_REG  = 1,
  parameter int TAG_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_SIZE-1:0]         a_i,
  input  logic [DATA_SIZE-1:0]         b_i,
  input  logic                         signed_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [prod_w(DATA_SIZE)-1:0] product_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic                         busy_o
);

  localparam int N     = DATA_SIZE;
  localparam int PW    = prod_w(DATA_SIZE);
  localparam int DEPTH = csa_depth(DATA_SIZE);

  logic                stall;
  logic                v1_q, v3_q, valid_mid;
  logic [N-1:0]        a_q, b_q;
  logic [TAG_W-1:0]    tag1_q, tag_q;
  logic [PW-1:0]       product_q, product_d;
  logic [PW-1:0]       cpa_s, cpa_c;
  logic [TAG_W-1:0]    cpa_tag;
  logic                cpa_v;
  stage_valid_t        valid;
  logic [DEPTH:0][N-1:0][PW-1:0] tree;

  assign stall      = v3_q & ~out_ready_i;
  assign in_ready_o = ~stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
    end else if (!stall) begin
      v1_q   <= in_valid_i;
      a_q    <= a_i;
      b_q    <= b_i;
      tag1_q <= tag_i;
    end
  end

`ifdef MULT_SIGNED_EN
  logic sgn_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     sgn_q <= 1'b0;
    else if (!stall) sgn_q <= signed_i;
  end
`endif

  // Row gi = a & b[gi] shifted by gi; row 0 also carries the signed-mode constants.
  for (genvar gi = 0; gi < N; gi++) begin : g_pp
    logic [PW-1:0] pp;
    always_comb begin
      pp = '0;
      for (int j = 0; j < N; j++) begin
        pp[gi+j] = a_q[j] & b_q[gi];
`ifdef MULT_SIGNED_EN
        if (sgn_q && ((j == N-1) != (gi == N-1))) pp[gi+j] = ~(a_q[j] & b_q[gi]);
`endif
      end
`ifdef MULT_SIGNED_EN
      if (gi == 0 && sgn_q) begin
        pp[N]    = 1'b1;
        pp[PW-1] = 1'b1;
      end
`endif
    end
    assign tree[0][gi] = pp;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_layer
    localparam int RI = rows_after(N, gi);
    localparam int RO = rows_after(N, gi + 1);
    csa_layer #(.ROWS_IN(RI), .W(PW)) u_csa (
      .rows_i(tree[gi][RI-1:0]),
      .rows_o(tree[gi+1][RO-1:0])
    );
    assign tree[gi+1][N-1:RO] = '0;
  end

  if (TREE_REG != 0) begin : g_tree_reg
    logic [PW-1:0]    s_q, c_q;
    logic [TAG_W-1:0] tag2_q;
    logic             v2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v2_q   <= 1'b0;
        s_q    <= '0;
        c_q    <= '0;
        tag2_q <= '0;
      end else if (!stall) begin
        v2_q   <= v1_q;
        s_q    <= tree[DEPTH][0];
        c_q    <= tree[DEPTH][1];
        tag2_q <= tag1_q;
      end
    end
    assign cpa_s     = s_q;
    assign cpa_c     = c_q;
    assign cpa_tag   = tag2_q;
    assign cpa_v     = v2_q;
    assign valid_mid = v2_q;
  end else begin : g_tree_comb
    assign cpa_s     = tree[DEPTH][0];
    assign cpa_c     = tree[DEPTH][1];
    assign cpa_tag   = tag1_q;
    assign cpa_v     = v1_q;
    assign valid_mid = 1'b0;
  end

  assign product_d = cpa_s + cpa_c;

  // Output data only loads on a valid entry so product_o stays 0 until the first result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3_q      <= 1'b0;
      product_q <= '0;
      tag_q     <= '0;
    end else if (!stall) begin
      v3_q <= cpa_v;
      if (cpa_v) begin
        product_q <= product_d;
        tag_q     <= cpa_tag;
      end
    end
  end

  assign valid       = {v3_q, valid_mid, v1_q};
  assign busy_o      = |valid;
  assign out_valid_o = v3_q;
  assign product_o   = product_q;
  assign tag_o       = tag_q;

endmodule
